// File: rtl/loopback_pkg.sv
// rtl/loopback_pkg.sv - shared types and defaults for the buffered UART receiver
// Contents: receiver FSM state encoding, default OVERSAMPLE and FIFO_DEPTH,
//           received data width.
package loopback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DATA_WIDTH         = 8;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - first-word fall-through receive FIFO with registered flags
// Ports: clk, reset (async active-low); wr/wr_data push one byte; rd pops the
//        head; data_out is the head byte; data_present/half_full/full flags;
//        overrun pulses for one clk when a push is dropped.
module rx_fifo
  import loopback_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_present,
  output logic                  half_full,
  output logic                  full,
  output logic                  overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   HALF_CNT = FULL_CNT >> 1;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_next;
  logic [AW:0]           count;
  logic [AW:0]           count_next;
  logic                  do_rd;
  logic                  do_wr;

  // A pop while full frees a slot in the same clk, so the push is accepted.
  always_comb begin
    do_rd       = rd && (count != '0);
    do_wr       = wr && ((count != FULL_CNT) || do_rd);
    rd_ptr_next = do_rd ? rd_ptr + PTR_ONE : rd_ptr;
    count_next  = count;
    if (do_wr && !do_rd) begin
      count_next = count + CNT_ONE;
    end else if (!do_wr && do_rd) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      data_present <= 1'b0;
      half_full    <= 1'b0;
      full         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      overrun      <= wr && !do_wr;
      data_present <= (count_next != '0);
      half_full    <= (count_next >= HALF_CNT);
      full         <= (count_next == FULL_CNT);
      // Head register: bypass the incoming byte when it lands on the new head slot.
      if (count_next == '0) begin
        data_out <= '0;
      end else if (do_wr && (wr_ptr == rd_ptr_next)) begin
        data_out <= wr_data;
      end else begin
        data_out <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 8N1 UART receiver with oversampling FSM and receive FIFO
// Ports: clk, reset (async active-low); en_16_x_baud oversample tick;
//        serial_in raw RS-232 line; read_buffer pop strobe; data_out head byte;
//        buffer_data_present/buffer_half_full/buffer_full flags;
//        framing_error and overrun one-clk pulses.
module uart_rx_buffered
  import loopback_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_16_x_baud,
  input  logic                  serial_in,
  input  logic                  read_buffer,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  buffer_data_present,
  output logic                  buffer_half_full,
  output logic                  buffer_full,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic                  sync_meta;
  logic                  sync_line;
  logic                  prev_sample;
  rx_state_t             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  fifo_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync_line <= sync_meta;
    end
  end

  // Good stop bit: push the assembled byte in the same clk as the sample tick.
  assign fifo_wr = (state == ST_STOP) && en_16_x_baud && (tick_cnt == LAST_TICK) && sync_line;

  // prev_sample resets to 0 so a line that is low when reset releases cannot
  // look like a start edge; a genuine 1->0 transition is required. The same
  // rule keeps a held-low break from retriggering after its framing error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      prev_sample   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      if (en_16_x_baud) begin
        prev_sample <= sync_line;
        case (state)
          ST_IDLE: begin
            if (!sync_line && prev_sample) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == HALF_TICK) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= sync_line ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          ST_DATA: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {sync_line, shift_reg[DATA_WIDTH-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BIT_ONE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          ST_STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt      <= '0;
              framing_error <= !sync_line;
              state         <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr          (fifo_wr),
    .wr_data     (shift_reg),
    .rd          (read_buffer),
    .data_out    (data_out),
    .data_present(buffer_data_present),
    .half_full   (buffer_half_full),
    .full        (buffer_full),
    .overrun     (overrun)
  );

endmodule
